data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-requester arbiter and access sequencer for the 256-entry x 32-bit data memory of the multi-cycle processor.
- Port 0 is the CPU load/store path. Port 1 is the debug/loader path.
- Grants one requester at a time with round-robin fairness, drives the memory's address/write-enable/write-data, captures read data, and returns an acknowledge.
- Rejects out-of-range addresses with an error response; the memory itself is never touched in that case.

Parameters:
- ADDR_W, 16, requester and memory address width.
- DATA_W, 32, data width.
- MEM_DEPTH, 256, number of implemented words; addresses >= MEM_DEPTH are out of range.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  CPU request; held high with fields stable until m0_ack.
- m0_we  in  1  CPU write (1) / read (0).
- m0_addr  in  ADDR_W  CPU word address.
- m0_wdata  in  DATA_W  CPU write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_W  read data; valid while m0_ack=1.
- m0_err  out  1  out-of-range flag; valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err: same as the m0_* ports, for the debug requester.
- mem_addr  out  ADDR_W  to memory data_address.
- mem_we  out  1  to memory write_en.
- mem_wdata  out  DATA_W  to memory write_data.
- mem_rdata  in  DATA_W  from memory read_data (combinational read).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (sync, active-high) values:
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - Latched addr/wdata/we/owner = 0.
  - All ack/err/rdata outputs 0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any req is high, arbitrate and latch the winner's we/addr/wdata/id; go to ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port not equal to last_grant wins (round-robin).
  - last_grant updates on every grant.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr, mem_wdata = latched wdata.
  - mem_we = latched_we AND in_range. The memory write is level-sensitive, so mem_we must be high in ACCESS only and low in all other states.
  - Register mem_rdata into rdata_q; rdata_q = 0 if the access is a write or out of range.
  - Register err_q = NOT in_range.
  - Go to RESP.
- in_range: latched addr < MEM_DEPTH, full ADDR_W compare.
- RESP (1 cycle):
  - Owner's ack=1, owner's rdata=rdata_q, owner's err=err_q.
  - The non-owner's ack/err/rdata stay 0.
  - Go to IDLE.
- Latency and throughput:
  - Request first seen high in IDLE at edge N -> ack high in cycle N+2.
  - One access per 3 cycles.
- Requester rule:
  - The requester deasserts req, or presents a new request, at the edge that ends its ack cycle.
  - A req still high in the following IDLE cycle is treated as a new request.
- Input changes while not in IDLE are ignored; fields are latched only in IDLE.
- Out-of-range write: no memory write; ack with err=1, rdata=0.
- Reset mid-operation (ACCESS or RESP): next edge returns to IDLE. No ack is issued for the aborted access; mem_we low from that edge.
- The arbiter is the only driver of the memory ports.

Decomposition:
- Package data_mem_arb_pkg:
  - State enum {IDLE, ACCESS, RESP}.
  - MEM_DEPTH default.
  - Requester id constants REQ_CPU=0, REQ_DBG=1.
- Sub-module rr_arbiter2:
  - Inputs: req[1:0], last_grant, grant-enable.
  - Outputs: one-hot grant and winner id.
  - Registers last_grant internally, with clk/rst.

Test Plan:
- Single CPU read: m0_req, addr=0x0005 while memory holds 5 at word 5 -> m0_ack exactly 2 cycles after request, m0_rdata=5, m0_err=0; mem_we never high.
- Single debug write then CPU read: m1 write addr=0x0010, data=0xDEADBEEF -> mem_we high exactly one cycle (ACCESS) with mem_addr=0x0010; then m0 read of 0x0010 returns 0xDEADBEEF.
- Simultaneous requests after reset: m0 and m1 both reads -> m0 served first (ack at +2), m1 served next (ack at +5); with both held requesting continuously, grants alternate 0,1,0,1.
- Out of range: m0 write addr=0x0100, data=0x12345678 -> mem_we stays 0, m0_ack with m0_err=1 and m0_rdata=0; a subsequent read of word 0x00 is unchanged.
- Reset mid-access: assert rst during ACCESS of an m1 write -> no m1_ack; busy=0 and mem_we=0 after the edge; last_grant=1, so a new tie grants m0.
- Back-to-back: m0 re-requests at the edge ending its ack cycle with m1 idle -> second ack exactly 3 cycles after the first.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
// Requester ids index the {m1, m0} request vector.
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int MEM_DEPTH_DEF = 256;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, combinational grant, registered last_grant.
// No backpressure: a grant is issued whenever enabled and any request is high.
module rr_arbiter2
  import data_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] grant,
  output logic       winner,
  output logic       last_grant
);

  always_comb begin
    winner = REQ_CPU;
    grant  = 2'b00;
    case (req)
      2'b01:   winner = REQ_CPU;
      2'b10:   winner = REQ_DBG;
      2'b11:   winner = ~last_grant;
      default: winner = REQ_CPU;
    endcase
    if (grant_en && (req != 2'b00)) begin
      grant = (winner == REQ_DBG) ? 2'b10 : 2'b01;
    end
  end

  // Reset to the debug port so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_DBG;
    end else if (grant != 2'b00) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU/debug access to the data memory; ack two cycles after grant.
// Requesters hold req until ack; one access per three cycles.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              owner_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [1:0]        grant;
  logic              winner;
  logic              last_grant;
  logic              in_range;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        ({m1_req, m0_req}),
    .grant_en   (state_q == IDLE),
    .grant      (grant),
    .winner     (winner),
    .last_grant (last_grant)
  );

  // Extra bit keeps the compare correct even if MEM_DEPTH == 2**ADDR_W.
  assign in_range = {1'b0, addr_q} < (ADDR_W+1)'(MEM_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant != 2'b00) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      owner_q <= REQ_CPU;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (grant != 2'b00) begin
        owner_q <= winner;
        if (winner == REQ_DBG) begin
          we_q    <= m1_we;
          addr_q  <= m1_addr;
          wdata_q <= m1_wdata;
        end else begin
          we_q    <= m0_we;
          addr_q  <= m0_addr;
          wdata_q <= m0_wdata;
        end
      end
      if (state_q == ACCESS) begin
        rdata_q <= (we_q || !in_range) ? '0 : mem_rdata;
        err_q   <= !in_range;
      end
    end
  end

  // Memory write is level-sensitive, so write-enable is confined to ACCESS.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = (state_q == ACCESS) && we_q && in_range;
    busy      = (state_q != IDLE);
    m0_ack    = (state_q == RESP) && (owner_q == REQ_CPU);
    m1_ack    = (state_q == RESP) && (owner_q == REQ_DBG);
    m0_rdata  = m0_ack ? rdata_q : '0;
    m1_rdata  = m1_ack ? rdata_q : '0;
    m0_err    = m0_ack && err_q;
    m1_err    = m1_ack && err_q;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized and directed bench for data_mem_arbiter against a transaction-level model.
module tb_data_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr, mem_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err, mem_we, busy;
  logic        preload;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        lg;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory array with combinational read, preloaded with word i = i.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Applies one access to the reference memory and returns its response.
  task automatic model_exec(input txn_t t, output logic [31:0] rd, output logic err,
                            output logic wr);
    err = (t.addr >= 16'd256);
    wr  = t.we && !err;
    rd  = 32'd0;
    if (!err) begin
      if (t.we) ref_mem[t.addr[7:0]] = t.wdata;
      else      rd = ref_mem[t.addr[7:0]];
    end
  endtask

  task automatic drive0(input logic r, input txn_t t);
    m0_req = r; m0_we = t.we; m0_addr = t.addr; m0_wdata = t.wdata;
  endtask

  task automatic drive1(input logic r, input txn_t t);
    m1_req = r; m1_we = t.we; m1_addr = t.addr; m1_wdata = t.wdata;
  endtask

  function automatic txn_t mk(input logic we, input logic [15:0] addr, input logic [31:0] d);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = d;
    return t;
  endfunction

  // Issue requests on the selected ports together; each port drops req after its ack.
  task automatic run_pair(input logic r0, input logic r1, input txn_t a0, input txn_t a1);
    logic        first, both, wfirst, wsecond, e0, e1, w0, w1, x0, x1;
    logic [31:0] rd0, rd1;
    logic [15:0] afirst, asecond;
    int          cyc0, cyc1, ncyc;
    both = r0 && r1;
    first = both ? ~lg : r1;
    cyc0 = 0; cyc1 = 0; rd0 = 0; rd1 = 0; e0 = 0; e1 = 0; w0 = 0; w1 = 0;
    if (first == 1'b0) begin
      model_exec(a0, rd0, e0, w0); cyc0 = 2;
      if (r1) begin model_exec(a1, rd1, e1, w1); cyc1 = 5; end
    end else begin
      model_exec(a1, rd1, e1, w1); cyc1 = 2;
      if (r0) begin model_exec(a0, rd0, e0, w0); cyc0 = 5; end
    end
    lg      = both ? ~first : first;
    wfirst  = first ? w1 : w0;
    afirst  = first ? a1.addr : a0.addr;
    wsecond = both ? (first ? w0 : w1) : 1'b0;
    asecond = first ? a0.addr : a1.addr;
    ncyc    = both ? 6 : 3;
    drive0(r0, a0);
    drive1(r1, a1);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      x0 = r0 && (c == cyc0);
      x1 = r1 && (c == cyc1);
      check("m0_ack", 32'(m0_ack), 32'(x0));
      check("m0_rdata", m0_rdata, x0 ? rd0 : 32'd0);
      check("m0_err", 32'(m0_err), 32'(x0 && e0));
      check("m1_ack", 32'(m1_ack), 32'(x1));
      check("m1_rdata", m1_rdata, x1 ? rd1 : 32'd0);
      check("m1_err", 32'(m1_err), 32'(x1 && e1));
      check("busy", 32'(busy), 32'((c % 3) != 0));
      check("mem_we", 32'(mem_we), 32'((c == 1 && wfirst) || (c == 4 && wsecond)));
      if (c == 1 && wfirst)  check("mem_addr", 32'(mem_addr), 32'(afirst));
      if (c == 4 && wsecond) check("mem_addr", 32'(mem_addr), 32'(asecond));
      if (m0_ack) m0_req = 1'b0;
      if (m1_ack) m1_req = 1'b0;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    lg  = 1'b1;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(256, 65535))
                                          : 16'($urandom_range(0, 40));
    t.wdata = $urandom;
    return t;
  endfunction

  initial begin
    txn_t        ta, tb2, tw;
    logic [31:0] rda, rdb;
    logic        ea, eb, wa, wb, xa;
    logic [1:0]  sel;

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
    drive0(1'b0, mk(1'b0, 16'd0, 32'd0));
    drive1(1'b0, mk(1'b0, 16'd0, 32'd0));
    preload = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    preload = 1'b0;
    rst = 1'b0;
    lg = 1'b1;

    // Single CPU read, debug write then CPU read.
    run_pair(1'b1, 1'b0, mk(1'b0, 16'h0005, 32'd0), mk(1'b0, 16'd0, 32'd0));
    run_pair(1'b0, 1'b1, mk(1'b0, 16'd0, 32'd0), mk(1'b1, 16'h0010, 32'hDEADBEEF));
    run_pair(1'b1, 1'b0, mk(1'b0, 16'h0010, 32'd0), mk(1'b0, 16'd0, 32'd0));

    // Ties after reset: CPU first, then alternating.
    do_reset();
    run_pair(1'b1, 1'b1, mk(1'b0, 16'h0003, 32'd0), mk(1'b0, 16'h0004, 32'd0));
    run_pair(1'b1, 1'b1, mk(1'b0, 16'h0007, 32'd0), mk(1'b0, 16'h0008, 32'd0));
    run_pair(1'b1, 1'b1, mk(1'b1, 16'h0009, 32'h11111111), mk(1'b0, 16'h0009, 32'd0));

    // Out-of-range write must not alias onto word 0.
    run_pair(1'b1, 1'b0, mk(1'b1, 16'h0100, 32'h12345678), mk(1'b0, 16'd0, 32'd0));
    run_pair(1'b1, 1'b0, mk(1'b0, 16'h0000, 32'd0), mk(1'b0, 16'd0, 32'd0));

    // Reset during ACCESS of a debug write: the write lands, no ack follows.
    tw = mk(1'b1, 16'h0020, 32'hCAFEF00D);
    drive1(1'b1, tw);
    @(posedge clk);
    @(negedge clk);
    check("abort_mem_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_we_off", 32'(mem_we), 32'd0);
    check("abort_m1_ack", 32'(m1_ack), 32'd0);
    rst = 1'b0;
    m1_req = 1'b0;
    ref_mem[8'h20] = tw.wdata;
    lg = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_no_late_ack", 32'(m1_ack), 32'd0);
    run_pair(1'b1, 1'b1, mk(1'b0, 16'h0020, 32'd0), mk(1'b0, 16'h0021, 32'd0));

    // Back-to-back CPU requests: second ack three cycles after the first.
    ta  = mk(1'b0, 16'h0010, 32'd0);
    tb2 = mk(1'b1, 16'h0030, 32'hA5A5F00F);
    model_exec(ta, rda, ea, wa);
    model_exec(tb2, rdb, eb, wb);
    lg = 1'b0;
    drive0(1'b1, ta);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      xa = (c == 2) || (c == 5);
      check("b2b_ack", 32'(m0_ack), 32'(xa));
      check("b2b_rdata", m0_rdata, (c == 2) ? rda : 32'd0);
      check("b2b_busy", 32'(busy), 32'((c % 3) != 0));
      check("b2b_mem_we", 32'(mem_we), 32'(c == 4 && wb));
      if (c == 2) drive0(1'b1, tb2);
      if (c == 5) m0_req = 1'b0;
    end

    for (int n = 0; n < 40; n++) begin
      sel = 2'($urandom_range(1, 3));
      run_pair(sel[0], sel[1], rand_txn(), rand_txn());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
